alu_datapath: RTL and testbench

Execution-stage datapath slice of the 8-bit processor core. It contains three pieces:
- an add/subtract ALU;
- the ALU B-operand 2:1 select (register file vs instruction immediate);
- the register-file write-back 4:1 select (ALU result, immediate, memory load, rd0 pass-through).

Result and write-back data are combinational. Zero/carry flags are held in a clocked flag register that the controller samples for conditional jumps.

---
 rtl/alu_datapath_pkg.sv | 21 ++
 rtl/alu_addsub.sv | 54 +++++
 rtl/alu_datapath.sv | 97 +++++++++
 tb/tb_alu_datapath.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_datapath_pkg.sv
// Shared types and constants for the execution-stage datapath slice.
// Holds the operand-B and write-back select encodings and the default data width.
package alu_datapath_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  // ALU operand B source
  typedef enum logic {
    REGISTER_FILE = 1'b0,
    IMMEDIATE     = 1'b1
  } b_sel_t;

  // Register-file write-back source
  typedef enum logic [1:0] {
    ALU_OUTPUT     = 2'd0,
    INST_IMMEDIATE = 2'd1,
    MEM_LOAD       = 2'd2,
    REG_FILE_RD0   = 2'd3
  } wb_sel_t;

endpackage

// File: rtl/alu_addsub.sv
// Parameterized adder/subtractor for the execution stage.
// Subtraction is A + ~B + 1, so carry out doubles as "no borrow".
// All outputs are forced to 0 while reset is high.
// Optional build macro: ALU_OVERFLOW_EN adds the signed-overflow output ovf.
import alu_datapath_pkg::*;

module alu_addsub #(
  parameter int WIDTH = DEFAULT_DATA_BITS
) (
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  assign b_eff = subtract ? ~b : b;
  // One extra bit captures the carry out; subtract is also the carry in.
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};

`ifdef ALU_OVERFLOW_EN
  logic carry_into_msb;
  // The MSB sum bit is a^b^cin, so the carry into the MSB falls out by XOR.
  assign carry_into_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
`endif

  // Result/flag outputs, zeroed while reset is held
  always_comb begin
    result = '0;
    cout   = 1'b0;
    zero   = 1'b0;
`ifdef ALU_OVERFLOW_EN
    ovf    = 1'b0;
`endif
    if (!reset) begin
      result = sum[WIDTH-1:0];
      cout   = sum[WIDTH];
      zero   = (sum[WIDTH-1:0] == '0);
`ifdef ALU_OVERFLOW_EN
      ovf    = carry_into_msb ^ sum[WIDTH];
`endif
    end
  end

endmodule

// File: rtl/alu_datapath.sv
// Execution-stage datapath slice: operand-B select, add/subtract ALU,
// write-back select and the clocked zero/carry flag register used by the
// controller for conditional jumps.
// Optional build macro: ALU_OVERFLOW_EN adds alu_ovf and ovf_flag.
import alu_datapath_pkg::*;

module alu_datapath #(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] rd0_data,
  input  logic [DATA_BITS-1:0] rd1_data,
  input  logic [DATA_BITS-1:0] imm,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 subtract,
  input  logic                 b_sel,
  input  logic [1:0]           wb_sel,
  input  logic                 flags_we,
  output logic [DATA_BITS-1:0] alu_result,
  output logic                 alu_cout,
  output logic                 alu_zero,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 zero_flag,
  output logic                 carry_flag
`ifdef ALU_OVERFLOW_EN
  ,
  output logic                 alu_ovf,
  output logic                 ovf_flag
`endif
);

  logic [DATA_BITS-1:0] operand_b;
  logic                 zero_flag_reg;
  logic                 carry_flag_reg;
`ifdef ALU_OVERFLOW_EN
  logic                 ovf_flag_reg;
`endif

  // Operand B: register file read port 1 or the instruction immediate
  always_comb begin
    operand_b = rd1_data;
    if (b_sel == IMMEDIATE) operand_b = imm;
  end

  alu_addsub #(
    .WIDTH (DATA_BITS)
  ) u_alu (
    .reset    (reset),
    .a        (rd0_data),
    .b        (operand_b),
    .subtract (subtract),
    .result   (alu_result),
    .cout     (alu_cout),
    .zero     (alu_zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .ovf      (alu_ovf)
`endif
  );

  // Write-back source select; ALU source reads 0 during reset via forcing
  always_comb begin
    wb_data = alu_result;
    case (wb_sel_t'(wb_sel))
      ALU_OUTPUT:     wb_data = alu_result;
      INST_IMMEDIATE: wb_data = imm;
      MEM_LOAD:       wb_data = load_data;
      REG_FILE_RD0:   wb_data = rd0_data;
      default:        wb_data = alu_result;
    endcase
  end

  // Flag register: capture on flags_we, hold otherwise, clear on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_flag_reg  <= 1'b0;
      carry_flag_reg <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      ovf_flag_reg   <= 1'b0;
`endif
    end else if (flags_we) begin
      zero_flag_reg  <= alu_zero;
      carry_flag_reg <= alu_cout;
`ifdef ALU_OVERFLOW_EN
      ovf_flag_reg   <= alu_ovf;
`endif
    end
  end

  assign zero_flag  = zero_flag_reg;
  assign carry_flag = carry_flag_reg;
`ifdef ALU_OVERFLOW_EN
  assign ovf_flag   = ovf_flag_reg;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed steps followed by random
// operations compared against an arithmetic reference model.
// Optional build macro: ALU_OVERFLOW_EN enables the overflow checks.
module tb_alu_datapath;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] rd0_data, rd1_data, imm, load_data;
  logic         subtract, b_sel, flags_we;
  logic [1:0]   wb_sel;
  logic [W-1:0] alu_result, wb_data;
  logic         alu_cout, alu_zero, zero_flag, carry_flag;
`ifdef ALU_OVERFLOW_EN
  logic         alu_ovf, ovf_flag;
`endif

  int tests = 0;
  int fails = 0;

  // model flag state
  logic m_zf, m_cf, m_vf;

  alu_datapath #(.DATA_BITS(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd0_data   (rd0_data),
    .rd1_data   (rd1_data),
    .imm        (imm),
    .load_data  (load_data),
    .subtract   (subtract),
    .b_sel      (b_sel),
    .wb_sel     (wb_sel),
    .flags_we   (flags_we),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_zero   (alu_zero),
    .wb_data    (wb_data),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
`ifdef ALU_OVERFLOW_EN
    ,
    .alu_ovf    (alu_ovf),
    .ovf_flag   (ovf_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the selected operands
  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, output logic [W-1:0] r,
                                  output logic c, output logic z, output logic v);
    int ai, bi, s, sa, sb, ss;
    ai = int'(a);
    bi = int'(b);
    if (sub) begin
      s = ai - bi;
      c = (ai >= bi);
    end else begin
      s = ai + bi;
      c = (s > 255);
    end
    r  = s[W-1:0];
    z  = (r == 0);
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    ss = sub ? sa - sb : sa + sb;
    v  = (ss > 127) || (ss < -128);
  endfunction

  function automatic logic [W-1:0] ref_wb(input logic [1:0] sel, input logic [W-1:0] r);
    case (sel)
      2'd0:    return r;
      2'd1:    return imm;
      2'd2:    return load_data;
      default: return rd0_data;
    endcase
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] r1, input logic [W-1:0] im,
                       input logic sub, input logic bs);
    rd0_data = a;
    rd1_data = r1;
    imm      = im;
    subtract = sub;
    b_sel    = bs;
  endtask

  // Compare the combinational outputs against the model for the current inputs
  task automatic check_comb(input string tag);
    logic [W-1:0] r;
    logic c, z, v;
    ref_alu(rd0_data, b_sel ? imm : rd1_data, subtract, r, c, z, v);
    if (reset) begin
      r = '0; c = 1'b0; z = 1'b0; v = 1'b0;
    end
    chk({tag, ".result"}, 32'(alu_result), 32'(r));
    chk({tag, ".cout"},   32'(alu_cout),   32'(c));
    chk({tag, ".zero"},   32'(alu_zero),   32'(z));
    chk({tag, ".wb"},     32'(wb_data),    32'(ref_wb(wb_sel, r)));
`ifdef ALU_OVERFLOW_EN
    chk({tag, ".ovf"},    32'(alu_ovf),    32'(v));
`endif
  endtask

  // One rising edge with flags_we=1; model updates from its own arithmetic
  task automatic capture_flags(input string tag);
    logic [W-1:0] r;
    logic c, z, v;
    ref_alu(rd0_data, b_sel ? imm : rd1_data, subtract, r, c, z, v);
    flags_we = 1'b1;
    @(posedge clk);
    #1;
    flags_we = 1'b0;
    if (!reset) begin
      m_zf = z; m_cf = c; m_vf = v;
    end
    check_flags(tag);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, ".zero_flag"},  32'(zero_flag),  32'(m_zf));
    chk({tag, ".carry_flag"}, 32'(carry_flag), 32'(m_cf));
`ifdef ALU_OVERFLOW_EN
    chk({tag, ".ovf_flag"},   32'(ovf_flag),   32'(m_vf));
`endif
  endtask

  initial begin
    reset = 1'b1; flags_we = 1'b0; wb_sel = 2'd0; load_data = 8'h5A;
    m_zf = 1'b0; m_cf = 1'b0; m_vf = 1'b0;
    drive(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    #2;
    // reset state: forced ALU outputs, wb source 0 reads 0, other sources pass
    check_comb("rst");
    check_flags("rst");
    wb_sel = 2'd1; #1; chk("rst.wb_imm", 32'(wb_data), 32'h56);
    wb_sel = 2'd0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // add via register operand
    drive(8'h05, 8'h03, 8'h00, 1'b0, 1'b0); #1;
    chk("add.result", 32'(alu_result), 32'h08);
    check_comb("add");
    capture_flags("add");

    // add with wrap through the immediate
    @(negedge clk);
    drive(8'hFF, 8'h00, 8'h01, 1'b0, 1'b1); #1;
    chk("wrap.result", 32'(alu_result), 32'h00);
    chk("wrap.cout", 32'(alu_cout), 32'h1);
    check_comb("wrap");
    capture_flags("wrap");
    chk("wrap.zf_set", 32'(zero_flag), 32'h1);

    // subtract with borrow, then subtract equal
    @(negedge clk);
    drive(8'h03, 8'h05, 8'h00, 1'b1, 1'b0); #1;
    chk("sub_borrow.result", 32'(alu_result), 32'hFE);
    check_comb("sub_borrow");
    drive(8'h42, 8'h00, 8'h42, 1'b1, 1'b1); #1;
    chk("sub_eq.cout", 32'(alu_cout), 32'h1);
    check_comb("sub_eq");

    // write-back select over all four sources
    drive(8'h11, 8'h33, 8'h22, 1'b0, 1'b0); load_data = 8'h33;
    for (int s = 0; s < 4; s++) begin
      logic [7:0] exp_wb [4];
      exp_wb = '{8'h44, 8'h22, 8'h33, 8'h11};
      wb_sel = 2'(s); #1;
      chk($sformatf("wb_sel%0d", s), 32'(wb_data), 32'(exp_wb[s]));
    end
    wb_sel = 2'd0;

    // flag hold: set zero flag, then 3 edges without flags_we on a nonzero result
    @(negedge clk);
    drive(8'hFF, 8'h00, 8'h01, 1'b0, 1'b1); #1;
    capture_flags("hold_set");
    @(negedge clk);
    drive(8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d.zero_flag", k), 32'(zero_flag), 32'h1);
    end

    // asynchronous reset between edges clears flags immediately
    #1;
    reset = 1'b1; #1;
    m_zf = 1'b0; m_cf = 1'b0; m_vf = 1'b0;
    check_flags("async_rst");
    chk("async_rst.result", 32'(alu_result), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // reset in the same edge as flags_we: reset wins
    drive(8'hFF, 8'h00, 8'h01, 1'b0, 1'b1); #1;
    capture_flags("pre_rstwe");
    @(negedge clk);
    reset = 1'b1;
    m_zf = 1'b0; m_cf = 1'b0; m_vf = 1'b0;
    capture_flags("rst_we");
    @(negedge clk);
    reset = 1'b0; #1;
    check_flags("rst_release");
    capture_flags("first_after_rst");
    chk("first_after_rst.cf", 32'(carry_flag), 32'h1);

`ifdef ALU_OVERFLOW_EN
    @(negedge clk);
    drive(8'h7F, 8'h00, 8'h01, 1'b0, 1'b1); #1;
    chk("ovf_pos", 32'(alu_ovf), 32'h1);
    capture_flags("ovf_cap");
    chk("ovf_cap.flag", 32'(ovf_flag), 32'h1);
    @(negedge clk);
    drive(8'h80, 8'h00, 8'h01, 1'b1, 1'b1); #1;
    chk("ovf_neg", 32'(alu_ovf), 32'h1);
    drive(8'h10, 8'h10, 8'h00, 1'b0, 1'b0); #1;
    chk("ovf_none", 32'(alu_ovf), 32'h0);
`endif

    // randomized operations against the reference model
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      load_data = 8'($urandom);
      wb_sel    = 2'($urandom);
      // bias some iterations toward equal operands to hit zero results
      if ($urandom_range(0, 7) == 0) begin
        rd1_data = rd0_data;
        imm      = rd0_data;
      end
      #1;
      check_comb($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        capture_flags($sformatf("rnd%0d", i));
      end else begin
        @(posedge clk); #1;
        check_flags($sformatf("rnd%0d.hold", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
